flag_ctx_stack: RTL and testbench
=================================

Name: flag_ctx_stack

Overview:
- Parametrised condition-flag register with a hardware save/restore stack for nested interrupts.
- Holds the active flag set. On interrupt entry it pushes the active set and starts the handler with cleared flags. On interrupt return it pops and restores the interrupted context.
- Sits between the ALU flag outputs and branch-condition logic. The interrupt controller drives entry and return.
- Supports nesting up to DEPTH levels, per-bit update masks and sticky error reporting.

Parameters:
- FLAG_W, 3, number of flag bits. Bit 0 = Z, bit 1 = OV, bit 2 = N; further bits are generic.
- DEPTH, 4, maximum saved contexts (nesting depth), >= 1.
- LVL_W, $clog2(DEPTH+1), width of the level counter (derived; not for override).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flags_in  in  FLAG_W  new flag values from the ALU.
- upd_mask  in  FLAG_W  per-bit write enable for flags_in.
- int_enter  in  1  single-cycle pulse: interrupt handler entry.
- int_return  in  1  single-cycle pulse: return from handler.
- clr_err  in  1  clears sticky error bits.
- flags_out  out  FLAG_W  active flag set, registered.
- level  out  LVL_W  number of saved contexts (0 = user mode).
- in_handler  out  1  asserted when level != 0 (combinational).
- overflow  out  1  sticky: entry attempted with the stack full.
- underflow  out  1  sticky: return attempted with the stack empty.

Behaviour:
- Reset (rst_n low, async): flags_out=0, level=0, overflow=0, underflow=0, all stack entries=0. in_handler=0.
- State: active register cur (drives flags_out), stack array stk[0..DEPTH-1], counter level.
- One-cycle latency for every event: the effect is visible on flags_out/level after the next rising clk.
- Each cycle, exactly one action applies, chosen by this priority:
  1. int_enter=1 and int_return=1 (tail-chain): stack and level unchanged; cur <= 0. Treated as exit of one handler plus entry of the next. At level 0 this is an underflow: set underflow, cur unchanged.
  2. int_enter=1 only:
     - level < DEPTH: stk[level] <= cur; level <= level+1; cur <= 0.
     - level == DEPTH: no push, cur and level unchanged; overflow <= 1.
  3. int_return=1 only:
     - level > 0: cur <= stk[level-1]; level <= level-1.
     - level == 0: cur unchanged; underflow <= 1.
  4. Neither pulse: for each bit i, cur[i] <= upd_mask[i] ? flags_in[i] : cur[i].
- Flag updates (upd_mask) are discarded in any cycle with int_enter or int_return asserted; the entry/return wins.
- The stack is LIFO with no wrap-around; entries at or above level are don't-care but are never exposed on outputs.
- clr_err=1: overflow <= 0 and underflow <= 0. If an error condition occurs in the same cycle, set wins.
- flags_out depends only on cur, never combinationally on inputs.
- rst_n asserted mid-nesting discards all saved contexts immediately; no restore occurs.

Test Plan:
- FLAG_W=3, DEPTH=2. Reset, then flags_in=3'b101, upd_mask=3'b111 -> next cycle flags_out=101, level=0. Then flags_in=3'b010, upd_mask=3'b001 -> flags_out=100.
- Nesting: with cur=101, pulse int_enter -> flags_out=000, level=1, in_handler=1. Update to 011, pulse int_enter -> flags_out=000, level=2. int_return -> flags_out=011, level=1. int_return -> flags_out=101, level=0.
- Overflow: at level=2 pulse int_enter -> level stays 2, flags_out unchanged, overflow=1 and stays 1. clr_err -> overflow=0.
- Underflow: at level=0 with flags_out=101, pulse int_return -> flags_out=101, level=0, underflow=1.
- Simultaneous events: at level=1, cur=110, assert int_enter+int_return together with upd_mask=111 -> flags_out=000, level=1, stk[0] unchanged. A following int_return restores the original user flags.
- Async reset: at level=2, drop rst_n between clock edges -> flags_out=000, level=0, errors=0 without waiting for a clk edge. After release, int_return sets underflow.

Source files
------------

// File: rtl/flag_ctx_stack.sv
// flag_ctx_stack: condition-flag register with a LIFO save/restore stack for
// nested interrupt contexts. Entry saves the active flags and starts the
// handler with cleared flags. Return restores the saved flags. Overflow and
// underflow attempts are reported through sticky error bits.
module flag_ctx_stack #(
  parameter int FLAG_W = 3,
  parameter int DEPTH  = 4,
  parameter int LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic [FLAG_W-1:0] upd_mask,
  input  logic              int_enter,
  input  logic              int_return,
  input  logic              clr_err,
  output logic [FLAG_W-1:0] flags_out,
  output logic [LVL_W-1:0]  level,
  output logic              in_handler,
  output logic              overflow,
  output logic              underflow
);

  logic [FLAG_W-1:0] cur;
  logic [FLAG_W-1:0] cur_nxt;
  logic [FLAG_W-1:0] stk [DEPTH];
  logic [FLAG_W-1:0] pop_val;
  logic [LVL_W-1:0]  lvl;
  logic [LVL_W-1:0]  lvl_nxt;
  logic              push;
  logic              ovf_set;
  logic              udf_set;
  logic              ovf;
  logic              udf;

  // Select the top-of-stack entry (index lvl-1); only consumed when lvl != 0.
  always_comb begin
    pop_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (LVL_W'(i) == (lvl - LVL_W'(1))) pop_val = stk[i];
    end
  end

  // Priority decode: tail-chain, entry, return, then masked flag update.
  always_comb begin
    cur_nxt = cur;
    lvl_nxt = lvl;
    push    = 1'b0;
    ovf_set = 1'b0;
    udf_set = 1'b0;
    if (int_enter && int_return) begin
      // Tail-chain leaves the stack alone; at user level there is no handler
      // to leave, so it counts as an underflow.
      if (lvl == '0) udf_set = 1'b1;
      else           cur_nxt = '0;
    end else if (int_enter) begin
      if (lvl < LVL_W'(DEPTH)) begin
        push    = 1'b1;
        lvl_nxt = lvl + LVL_W'(1);
        cur_nxt = '0;
      end else begin
        ovf_set = 1'b1;
      end
    end else if (int_return) begin
      if (lvl != '0) begin
        cur_nxt = pop_val;
        lvl_nxt = lvl - LVL_W'(1);
      end else begin
        udf_set = 1'b1;
      end
    end else begin
      cur_nxt = (flags_in & upd_mask) | (cur & ~upd_mask);
    end
  end

  // Active flags, level counter and sticky errors; error set beats clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= '0;
      lvl <= '0;
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      cur <= cur_nxt;
      lvl <= lvl_nxt;
      ovf <= ovf_set | (ovf & ~clr_err);
      udf <= udf_set | (udf & ~clr_err);
    end
  end

  // Context stack: the current flags are written at index lvl on a push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stk[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (LVL_W'(i) == lvl)) stk[i] <= cur;
      end
    end
  end

  assign flags_out  = cur;
  assign level      = lvl;
  assign in_handler = (lvl != '0);
  assign overflow   = ovf;
  assign underflow  = udf;

endmodule

// File: tb/tb_flag_ctx_stack.sv
// Testbench for flag_ctx_stack (FLAG_W=3, DEPTH=2). A behavioural model with a
// queue-based stack predicts each cycle; predictions are queued at drive time
// and popped when the DUT outputs are sampled after the clock edge.
module tb_flag_ctx_stack;

  localparam int FLAG_W = 3;
  localparam int DEPTH  = 2;
  localparam int LVL_W  = $clog2(DEPTH + 1);

  logic              clk;
  logic              rst_n;
  logic [FLAG_W-1:0] flags_in;
  logic [FLAG_W-1:0] upd_mask;
  logic              int_enter;
  logic              int_return;
  logic              clr_err;
  logic [FLAG_W-1:0] flags_out;
  logic [LVL_W-1:0]  level;
  logic              in_handler;
  logic              overflow;
  logic              underflow;

  flag_ctx_stack #(.FLAG_W(FLAG_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flags_in   (flags_in),
    .upd_mask   (upd_mask),
    .int_enter  (int_enter),
    .int_return (int_return),
    .clr_err    (clr_err),
    .flags_out  (flags_out),
    .level      (level),
    .in_handler (in_handler),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [FLAG_W-1:0] flags;
    logic [LVL_W-1:0]  lvl;
    logic              hnd;
    logic              ovf;
    logic              udf;
  } exp_t;

  exp_t              exp_q [$];
  logic [FLAG_W-1:0] m_stk [$];
  logic [FLAG_W-1:0] m_cur;
  logic              m_ovf;
  logic              m_udf;
  int                n_tests;
  int                n_fail;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cur = '0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
    m_stk.delete();
  endtask

  task automatic model_step(input logic en, input logic rt, input logic [FLAG_W-1:0] fin,
                            input logic [FLAG_W-1:0] mask, input logic clr);
    logic os, us;
    exp_t e;
    int sz;
    os = 1'b0;
    us = 1'b0;
    if (en && rt) begin
      if (m_stk.size() == 0) us = 1'b1;
      else m_cur = '0;
    end else if (en) begin
      if (m_stk.size() < DEPTH) begin
        m_stk.push_back(m_cur);
        m_cur = '0;
      end else os = 1'b1;
    end else if (rt) begin
      if (m_stk.size() > 0) m_cur = m_stk.pop_back();
      else us = 1'b1;
    end else begin
      m_cur = (m_cur & ~mask) | (fin & mask);
    end
    m_ovf = os | (m_ovf & ~clr);
    m_udf = us | (m_udf & ~clr);
    sz = m_stk.size();
    e.flags = m_cur;
    e.lvl   = LVL_W'(sz);
    e.hnd   = (sz != 0);
    e.ovf   = m_ovf;
    e.udf   = m_udf;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of stimulus (called just after a falling edge), then
  // compare the DUT against the oldest prediction shortly after the rising edge.
  task automatic cyc(input logic en, input logic rt, input logic [FLAG_W-1:0] fin,
                     input logic [FLAG_W-1:0] mask, input logic clr);
    exp_t e;
    int_enter  = en;
    int_return = rt;
    flags_in   = fin;
    upd_mask   = mask;
    clr_err    = clr;
    model_step(en, rt, fin, mask, clr);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 8'd1, 8'd0);
    end else begin
      e = exp_q.pop_front();
      check("flags_out", 8'(flags_out), 8'(e.flags));
      check("level", 8'(level), 8'(e.lvl));
      check("in_handler", 8'(in_handler), 8'(e.hnd));
      check("overflow", 8'(overflow), 8'(e.ovf));
      check("underflow", 8'(underflow), 8'(e.udf));
    end
    int_enter  = 1'b0;
    int_return = 1'b0;
    clr_err    = 1'b0;
    upd_mask   = '0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    flags_in   = '0;
    upd_mask   = '0;
    int_enter  = 1'b0;
    int_return = 1'b0;
    clr_err    = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_flags", 8'(flags_out), 8'd0);
    check("rst_level", 8'(level), 8'd0);
    check("rst_in_handler", 8'(in_handler), 8'd0);
    check("rst_ovf", 8'(overflow), 8'd0);
    check("rst_udf", 8'(underflow), 8'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Masked updates
    cyc(1'b0, 1'b0, 3'b101, 3'b111, 1'b0);
    check("plan_upd_all", 8'(flags_out), 8'b101);
    cyc(1'b0, 1'b0, 3'b010, 3'b001, 1'b0);
    check("plan_upd_mask", 8'(flags_out), 8'b100);
    cyc(1'b0, 1'b0, 3'b101, 3'b111, 1'b0);

    // Nesting two levels, flag update inside the first handler
    cyc(1'b1, 1'b0, 3'b111, 3'b111, 1'b0);
    check("plan_enter1_flags", 8'(flags_out), 8'b000);
    cyc(1'b0, 1'b0, 3'b011, 3'b111, 1'b0);
    cyc(1'b1, 1'b0, 3'b000, 3'b000, 1'b0);
    check("plan_enter2_level", 8'(level), 8'd2);

    // Overflow at full stack; sticky, set wins over clear, then cleared
    cyc(1'b0, 1'b0, 3'b110, 3'b111, 1'b0);
    cyc(1'b1, 1'b0, 3'b001, 3'b111, 1'b0);
    check("plan_ovf_flags", 8'(flags_out), 8'b110);
    cyc(1'b0, 1'b0, 3'b000, 3'b000, 1'b0);
    cyc(1'b1, 1'b0, 3'b000, 3'b000, 1'b1);
    check("plan_ovf_set_wins", 8'(overflow), 8'd1);
    cyc(1'b0, 1'b0, 3'b000, 3'b000, 1'b1);
    check("plan_ovf_clr", 8'(overflow), 8'd0);

    // Unwind
    cyc(1'b0, 1'b1, 3'b111, 3'b111, 1'b0);
    check("plan_ret1_flags", 8'(flags_out), 8'b011);
    cyc(1'b0, 1'b1, 3'b000, 3'b000, 1'b0);
    check("plan_ret0_flags", 8'(flags_out), 8'b101);

    // Underflow at level 0, also via tail-chain at level 0
    cyc(1'b0, 1'b1, 3'b000, 3'b000, 1'b0);
    check("plan_udf", 8'(underflow), 8'd1);
    cyc(1'b0, 1'b0, 3'b000, 3'b000, 1'b1);
    cyc(1'b1, 1'b1, 3'b010, 3'b111, 1'b0);
    check("tail_lvl0_flags", 8'(flags_out), 8'b101);
    cyc(1'b0, 1'b0, 3'b000, 3'b000, 1'b1);

    // Tail-chain at level 1 keeps the saved context
    cyc(1'b1, 1'b0, 3'b000, 3'b000, 1'b0);
    cyc(1'b0, 1'b0, 3'b110, 3'b111, 1'b0);
    cyc(1'b1, 1'b1, 3'b111, 3'b111, 1'b0);
    check("plan_tail_flags", 8'(flags_out), 8'b000);
    cyc(1'b0, 1'b1, 3'b000, 3'b000, 1'b0);
    check("plan_tail_restore", 8'(flags_out), 8'b101);

    // Random mix of events
    for (int i = 0; i < 60; i++) begin
      cyc(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
          3'($urandom), 3'($urandom), 1'($urandom_range(0, 5) == 0));
    end

    // Asynchronous reset mid-nesting, between clock edges
    cyc(1'b0, 1'b0, 3'b000, 3'b000, 1'b1);
    while (m_stk.size() != 0) cyc(1'b0, 1'b1, 3'b000, 3'b000, 1'b0);
    cyc(1'b0, 1'b0, 3'b111, 3'b111, 1'b0);
    cyc(1'b1, 1'b0, 3'b000, 3'b000, 1'b0);
    cyc(1'b0, 1'b0, 3'b011, 3'b111, 1'b0);
    cyc(1'b1, 1'b0, 3'b000, 3'b000, 1'b0);
    check("pre_arst_level", 8'(level), 8'd2);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_flags", 8'(flags_out), 8'd0);
    check("arst_level", 8'(level), 8'd0);
    check("arst_in_handler", 8'(in_handler), 8'd0);
    check("arst_ovf", 8'(overflow), 8'd0);
    check("arst_udf", 8'(underflow), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cyc(1'b0, 1'b1, 3'b000, 3'b000, 1'b0);
    check("post_arst_udf", 8'(underflow), 8'd1);

    check("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
